// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: state encoding, opcodes,
// ALU operation codes, register-encoder selects and instruction classes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_T7,
        ST_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        RSEL_A = 2'd0,
        RSEL_B = 2'd1,
        RSEL_C = 2'd2
    } rin_sel_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_IMM,
        CLS_LDI,
        CLS_LD,
        CLS_ST,
        CLS_NOP,
        CLS_HALT
    } instr_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: maps an opcode to its instruction class and the ALU
// operation used in its execute phase. Undefined opcodes behave as nop.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_t cls,
    output alu_op_t      alu_op
);

    always_comb begin
        cls    = CLS_NOP;
        alu_op = ALU_ADD;
        case (opcode)
            OP_ADD:  begin cls = CLS_RTYPE; alu_op = ALU_ADD; end
            OP_SUB:  begin cls = CLS_RTYPE; alu_op = ALU_SUB; end
            OP_AND:  begin cls = CLS_RTYPE; alu_op = ALU_AND; end
            OP_OR:   begin cls = CLS_RTYPE; alu_op = ALU_OR;  end
            OP_ADDI: begin cls = CLS_IMM;   alu_op = ALU_ADD; end
            OP_ANDI: begin cls = CLS_IMM;   alu_op = ALU_AND; end
            OP_ORI:  begin cls = CLS_IMM;   alu_op = ALU_OR;  end
            // Address arithmetic for ldi/ld/st is always base + offset.
            OP_LDI:  cls = CLS_LDI;
            OP_LD:   cls = CLS_LD;
            OP_ST:   cls = CLS_ST;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit stepping the bus datapath through fetch, decode and
// execute; memory states stall on mem_ready.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// T0    | PC onto bus, load MAR, increment PC
// T1    | instruction read, held until mem_ready
// T2    | MDR into IR
// T3    | decode; first operand (or base) into Y
// T4    | ALU op into Z
// T5    | Z to destination register, or to MAR for ld/st
// T6    | ld: data read (waits); st: source register into MDR
// T7    | ld: MDR to destination; st: data write (waits)
// HALT  | stopped until reset
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int IR_W = 32,
    parameter int OP_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IR_W-1:0] ir,
    input  logic            mem_ready,
    output logic            gra,
    output logic            grb,
    output logic            grc,
    output logic            rin,
    output logic            rout_a,
    output logic            rout_b,
    output logic            rout_c,
    output logic            ba_out,
    output logic [1:0]      rin_sel,
    output logic            pc_out,
    output logic            pc_in,
    output logic            inc_pc,
    output logic            mar_in,
    output logic            mdr_in,
    output logic            md_read,
    output logic            mdr_out,
    output logic            ir_in,
    output logic            y_in,
    output logic            z_in,
    output logic            z_lo_out,
    output logic            c_out,
    output logic [1:0]      alu_op,
    output logic            mem_read,
    output logic            mem_write,
    output logic            run
);

    state_t       state;
    state_t       state_nxt;
    instr_class_t cls;
    alu_op_t      dec_alu_op;

    // Register fields and immediates are consumed by the datapath, not here.
    logic unused_ir_fields;
    assign unused_ir_fields = ^ir[IR_W-OP_W-1:0];

    ctrl_decode u_decode (
        .opcode (ir[IR_W-1 -: OP_W]),
        .cls    (cls),
        .alu_op (dec_alu_op)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_T0;
            ST_T0:   state_nxt = ST_T1;
            ST_T1:   if (mem_ready) state_nxt = ST_T2;
            ST_T2:   state_nxt = ST_T3;
            ST_T3: begin
                case (cls)
                    CLS_NOP:  state_nxt = ST_T0;
                    CLS_HALT: state_nxt = ST_HALT;
                    default:  state_nxt = ST_T4;
                endcase
            end
            ST_T4:   state_nxt = ST_T5;
            ST_T5: begin
                if (cls == CLS_LD || cls == CLS_ST) begin
                    state_nxt = ST_T6;
                end else begin
                    state_nxt = ST_T0;
                end
            end
            // Only ld waits in T6; only st waits in T7.
            ST_T6: begin
                if (cls != CLS_LD || mem_ready) state_nxt = ST_T7;
            end
            ST_T7: begin
                if (cls == CLS_LD || mem_ready) state_nxt = ST_T0;
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        gra       = 1'b0;
        grb       = 1'b0;
        grc       = 1'b0;
        rin       = 1'b0;
        rout_a    = 1'b0;
        rout_b    = 1'b0;
        rout_c    = 1'b0;
        ba_out    = 1'b0;
        rin_sel   = RSEL_A;
        pc_out    = 1'b0;
        pc_in     = 1'b0;
        inc_pc    = 1'b0;
        mar_in    = 1'b0;
        mdr_in    = 1'b0;
        md_read   = 1'b0;
        mdr_out   = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        z_in      = 1'b0;
        z_lo_out  = 1'b0;
        c_out     = 1'b0;
        alu_op    = ALU_ADD;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        run       = (state != ST_IDLE) && (state != ST_HALT);
        case (state)
            ST_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
            end
            ST_T1: begin
                mem_read = 1'b1;
                md_read  = 1'b1;
                mdr_in   = 1'b1;
            end
            ST_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CLS_RTYPE, CLS_IMM: begin
                        grb     = 1'b1;
                        rout_b  = 1'b1;
                        rin_sel = RSEL_B;
                        y_in    = 1'b1;
                    end
                    // BAout gives r0-as-zero semantics for the base register.
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        grb     = 1'b1;
                        ba_out  = 1'b1;
                        rin_sel = RSEL_B;
                        y_in    = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CLS_RTYPE: begin
                        grc     = 1'b1;
                        rout_c  = 1'b1;
                        rin_sel = RSEL_C;
                        z_in    = 1'b1;
                        alu_op  = dec_alu_op;
                    end
                    CLS_IMM, CLS_LDI, CLS_LD, CLS_ST: begin
                        c_out  = 1'b1;
                        z_in   = 1'b1;
                        alu_op = dec_alu_op;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                z_lo_out = 1'b1;
                if (cls == CLS_LD || cls == CLS_ST) begin
                    mar_in = 1'b1;
                end else begin
                    gra = 1'b1;
                    rin = 1'b1;
                end
            end
            ST_T6: begin
                if (cls == CLS_LD) begin
                    mem_read = 1'b1;
                    md_read  = 1'b1;
                    mdr_in   = 1'b1;
                end else begin
                    gra    = 1'b1;
                    rout_a = 1'b1;
                    mdr_in = 1'b1;
                end
            end
            ST_T7: begin
                if (cls == CLS_LD) begin
                    mdr_out = 1'b1;
                    gra     = 1'b1;
                    rin     = 1'b1;
                end else begin
                    mem_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
